// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin sharing of one i2c_master between NUM_REQ clients.
// The owner's request is latched into the master command port, completion is the
// rising edge of transaction_done, and a watchdog turns a missing edge into err.
module i2c_arbiter #(
    parameter int unsigned NUM_REQ                   = 3,
    parameter int unsigned MAX_BYTES_PER_TRANSACTION = 3,
    parameter int unsigned TIMEOUT_CYCLES            = 100000,
    localparam int unsigned BW = $clog2(MAX_BYTES_PER_TRANSACTION + 1),
    localparam int unsigned MB = 8 * MAX_BYTES_PER_TRANSACTION
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_rd_nwr,
    input  logic [7*NUM_REQ-1:0]  req_addr,
    input  logic [BW*NUM_REQ-1:0] req_bytes_num,
    input  logic [MB*NUM_REQ-1:0] req_din,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic [NUM_REQ-1:0]    err,
    output logic [MB-1:0]         rd_data,
    output logic                  m_transaction_start,
    output logic                  m_rd_nwr,
    output logic [6:0]            m_slave_addr,
    output logic [BW-1:0]         m_bytes_num,
    output logic [MB-1:0]         m_din,
    input  logic [MB-1:0]         m_dout,
    input  logic                  m_transaction_done
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_WAIT, ST_FINISH} state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, owner_q;
    logic [TW-1:0]     timer_q;
    logic              done_q;
    logic [NUM_REQ-1:0] err_q;
    logic              m_rd_nwr_q;
    logic [6:0]        m_addr_q;
    logic [BW-1:0]     m_bytes_q;
    logic [MB-1:0]     m_din_q;
    logic [MB-1:0]     rd_data_q;

    logic [6:0]        addr_a  [NUM_REQ];
    logic [BW-1:0]     bytes_a [NUM_REQ];
    logic [MB-1:0]     din_a   [NUM_REQ];

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     cand_idx;
    int unsigned       cand;
    logic              len_ok, accept, done_edge, timeout;
    logic [NUM_REQ-1:0] owner_oh, pick_oh;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]  = req_addr[7*g +: 7];
        assign bytes_a[g] = req_bytes_num[BW*g +: BW];
        assign din_a[g]   = req_din[MB*g +: MB];
    end

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] p);
        return (p == IW'(NUM_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin search for the first requester starting at rr_ptr_q
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(rr_ptr_q) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IW'(cand);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // A client whose err is still pulsing is given one cycle to drop req,
    // so arbitration pauses while err_q is set.
    assign len_ok    = (bytes_a[pick_idx] != '0) &&
                       (32'(bytes_a[pick_idx]) <= MAX_BYTES_PER_TRANSACTION);
    assign accept    = (state_q == ST_IDLE) && pick_found && (err_q == '0);
    assign done_edge = m_transaction_done & ~done_q;
    assign timeout   = (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign owner_oh  = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign pick_oh   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && len_ok) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT:   if (done_edge || timeout) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Datapath: request latch, watchdog, read capture, error pulse, rr pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            timer_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= '0;
            m_rd_nwr_q <= 1'b0;
            m_addr_q   <= '0;
            m_bytes_q  <= '0;
            m_din_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            done_q <= m_transaction_done;
            err_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    if (accept) begin
                        owner_q    <= pick_idx;
                        m_rd_nwr_q <= req_rd_nwr[pick_idx];
                        m_addr_q   <= addr_a[pick_idx];
                        m_bytes_q  <= bytes_a[pick_idx];
                        m_din_q    <= din_a[pick_idx];
                        if (!len_ok) begin
                            err_q    <= pick_oh;
                            rr_ptr_q <= wrap_inc(pick_idx);
                        end
                    end
                end
                ST_LAUNCH: timer_q <= timer_q + 1'b1;
                ST_WAIT: begin
                    timer_q <= timer_q + 1'b1;
                    if (done_edge) begin
                        if (m_rd_nwr_q) rd_data_q <= m_dout;
                    end else if (timeout) begin
                        err_q <= owner_oh;
                    end
                end
                ST_FINISH: rr_ptr_q <= wrap_inc(owner_q);
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; done is suppressed when the watchdog fired
    always_comb begin
        grant               = '0;
        done                = '0;
        m_transaction_start = 1'b0;
        case (state_q)
            ST_LAUNCH: begin
                grant               = owner_oh;
                m_transaction_start = 1'b1;
            end
            ST_WAIT:   grant = owner_oh;
            ST_FINISH: if (err_q == '0) done = owner_oh;
            default: ;
        endcase
    end

    assign err          = err_q;
    assign rd_data      = rd_data_q;
    assign m_rd_nwr     = m_rd_nwr_q;
    assign m_slave_addr = m_addr_q;
    assign m_bytes_num  = m_bytes_q;
    assign m_din        = m_din_q;

endmodule
